// File: rtl/row_serializer_pkg.sv
// Shared coprocessor pixel/row parameters and types.
// Used by the read-side serializer and the write-side accumulator.
package row_serializer_pkg;

  localparam int PIX_W   = 12;
  localparam int ROW_PIX = 256;
  localparam int ROW_W   = PIX_W * ROW_PIX;
  localparam int COL_W   = $clog2(ROW_PIX);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

endpackage

// File: rtl/row_shift_buf.sv
// One row buffer: a ROW_W shift register plus its full flag.
// Loads a whole row, then shifts one pixel out per shift pulse.
module row_shift_buf
  import row_serializer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic             last,
  input  logic [ROW_W-1:0] d,
  output logic [PIX_W-1:0] q_lo,
  output logic             full
);

  logic [ROW_W-1:0] data_q, data_d;
  logic             full_q, full_d;

  assign q_lo = data_q[PIX_W-1:0];
  assign full = full_q;

  // Next state: clear beats load, load beats shift; last shift empties.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clr) begin
      full_d = 1'b0;
    end else if (load) begin
      data_d = d;
      full_d = 1'b1;
    end else if (shift) begin
      data_d = {{PIX_W{1'b0}}, data_q[ROW_W-1:PIX_W]};
      if (last) full_d = 1'b0;
    end
  end

  // Buffer and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/row_serializer.sv
// Ping-pong row-to-pixel serializer for the row bank read path.
// Loads whole rows, streams one pixel per cycle, pixel 0 first.
module row_serializer
  import row_serializer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             row_valid,
  output logic             row_ready,
  input  logic [ROW_W-1:0] row_data,
  input  logic             flush,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [PIX_W-1:0] pix_data,
  output logic [COL_W-1:0] pix_col,
  output logic             pix_last,
  output logic             busy
);

  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       full;
  logic [1:0]       load;
  logic [1:0]       shift;
  logic [PIX_W-1:0] q_lo [2];
  logic             row_fire;
  logic             pix_fire;
  logic             col_end;

  assign row_ready = ~full[wr_sel_q];
  assign pix_valid = full[rd_sel_q];
  assign pix_data  = q_lo[rd_sel_q];
  assign pix_col   = col_q;
  assign col_end   = (col_q == COL_W'(ROW_PIX - 1));
  assign pix_last  = pix_valid & col_end;
  assign busy      = |full;
  assign row_fire  = row_valid & row_ready & ~flush;
  assign pix_fire  = pix_valid & pix_ready & ~flush;

  // Steer load/shift to the selected buffers and advance selectors.
  always_comb begin
    load     = '0;
    shift    = '0;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    col_d    = col_q;
    load[wr_sel_q]  = row_fire;
    shift[rd_sel_q] = pix_fire;
    if (row_fire) wr_sel_d = ~wr_sel_q;
    if (pix_fire) begin
      if (col_end) begin
        col_d    = '0;
        rd_sel_d = ~rd_sel_q;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
    if (flush) begin
      wr_sel_d = 1'b0;
      rd_sel_d = 1'b0;
      col_d    = '0;
    end
  end

  // Selector and column registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      col_q    <= '0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      col_q    <= col_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_buf
    row_shift_buf u_buf (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .load  (load[i]),
      .shift (shift[i]),
      .last  (col_end),
      .d     (row_data),
      .q_lo  (q_lo[i]),
      .full  (full[i])
    );
  end

endmodule

// File: tb/tb_row_serializer.sv
// Directed self-checking bench for row_serializer.
// Inputs and checks happen on the falling edge.
module tb_row_serializer;
  import row_serializer_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             row_valid;
  logic             row_ready;
  logic [ROW_W-1:0] row_data;
  logic             flush;
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic [COL_W-1:0] pix_col;
  logic             pix_last;
  logic             busy;

  int checks = 0;
  int errors = 0;

  row_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .flush     (flush),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_col   (pix_col),
    .pix_last  (pix_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [PIX_W-1:0] pix(int b, int m, int k);
    return PIX_W'(k * m + b);
  endfunction

  function automatic logic [ROW_W-1:0] mk_row(int b, int m);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int k = 0; k < ROW_PIX; k++) r[PIX_W*k +: PIX_W] = pix(b, m, k);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; row_valid = 1'b0; row_data = '0;
    flush = 1'b0; pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (row_ready !== 1'b1) begin
      errors++; $display("FAIL reset_row_ready got %b want 1", row_ready);
    end
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++; $display("FAIL reset_pix_valid got %b want 0", pix_valid);
    end
    checks++;
    if (pix_data !== '0) begin
      errors++; $display("FAIL reset_pix_data got %h want 000", pix_data);
    end
    checks++;
    if (pix_col !== '0) begin
      errors++; $display("FAIL reset_pix_col got %0d want 0", pix_col);
    end
    checks++;
    if (pix_last !== 1'b0) begin
      errors++; $display("FAIL reset_pix_last got %b want 0", pix_last);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    pix_ready = 1'b1;
    row_valid = 1'b1;
    row_data  = mk_row(1, 3);
    checks++;
    if (row_ready !== 1'b1) begin
      errors++; $display("FAIL single_accept got %b want 1", row_ready);
    end
    @(negedge clk);
    row_valid = 1'b0;
    for (int k = 0; k < ROW_PIX; k++) begin
      checks++;
      if (pix_valid !== 1'b1 || pix_data !== pix(1, 3, k) ||
          pix_col !== COL_W'(k) || pix_last !== (k == ROW_PIX - 1)) begin
        errors++;
        $display("FAIL single_pix k=%0d got v%b d%h c%0d l%b want v1 d%h c%0d l%b",
                 k, pix_valid, pix_data, pix_col, pix_last,
                 pix(1, 3, k), k, (k == ROW_PIX - 1));
      end
      @(negedge clk);
    end
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end got v%b busy%b want v0 busy0", pix_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    int rb [3] = '{5, 9, 2};
    int rm [3] = '{7, 11, 13};
    int ri = 0, n = 0, bub = 0, gaps = 0;
    int last0 = -1, acc2 = -1;
    bit blk = 0, started = 0;
    pix_ready = 1'b1;
    for (int c = 0; c < 1000 && n < 3 * ROW_PIX; c++) begin
      if (pix_valid) begin
        checks++;
        if (pix_data !== pix(rb[n/ROW_PIX], rm[n/ROW_PIX], n % ROW_PIX) ||
            pix_col !== COL_W'(n % ROW_PIX)) begin
          errors++;
          $display("FAIL b2b_pix n=%0d got d%h c%0d want d%h c%0d", n, pix_data,
                   pix_col, pix(rb[n/ROW_PIX], rm[n/ROW_PIX], n % ROW_PIX),
                   n % ROW_PIX);
        end
        if (n == ROW_PIX - 1) last0 = c;
        n++;
        started = 1;
      end else if (started) begin
        gaps++;
      end
      row_valid = (ri < 3);
      row_data  = (ri < 3) ? mk_row(rb[ri], rm[ri]) : '0;
      if (row_valid && row_ready) begin
        if (ri == 2) acc2 = c;
        ri++;
        blk = 0;
      end else if (row_valid && !row_ready) begin
        if (!blk) bub++;
        blk = 1;
      end
      @(negedge clk);
    end
    row_valid = 1'b0;
    checks++;
    if (n !== 3 * ROW_PIX) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", n, 3 * ROW_PIX);
    end
    checks++;
    if (gaps !== 0) begin
      errors++; $display("FAIL b2b_gaps got %0d want 0", gaps);
    end
    checks++;
    if (bub !== 1) begin
      errors++; $display("FAIL b2b_bubbles got %0d want 1", bub);
    end
    checks++;
    if (last0 < 0 || acc2 !== last0 + 1) begin
      errors++;
      $display("FAIL b2b_row3_accept got %0d want %0d", acc2, last0 + 1);
    end
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got v%b busy%b want v0 busy0", pix_valid, busy);
    end
  endtask

  task automatic test_random();
    int rb [4] = '{3, 100, 7, 0};
    int rm [4] = '{5, 1, 9, 17};
    int acc = 0, n = 0, occ;
    bit stall = 0;
    logic [PIX_W-1:0] pd = '0;
    logic [COL_W-1:0] pc = '0;
    for (int c = 0; c < 6000 && n < 4 * ROW_PIX; c++) begin
      occ = acc - n / ROW_PIX;
      checks++;
      if (row_ready !== (occ < 2) || pix_valid !== (occ > 0)) begin
        errors++;
        $display("FAIL rnd_flags c=%0d got r%b v%b want r%b v%b", c, row_ready,
                 pix_valid, (occ < 2), (occ > 0));
      end
      if (stall) begin
        checks++;
        if (pix_data !== pd || pix_col !== pc) begin
          errors++;
          $display("FAIL rnd_hold c=%0d got d%h c%0d want d%h c%0d", c,
                   pix_data, pix_col, pd, pc);
        end
      end
      if (pix_valid) begin
        checks++;
        if (pix_data !== pix(rb[n/ROW_PIX], rm[n/ROW_PIX], n % ROW_PIX) ||
            pix_col !== COL_W'(n % ROW_PIX)) begin
          errors++;
          $display("FAIL rnd_pix n=%0d got d%h c%0d want d%h c%0d", n, pix_data,
                   pix_col, pix(rb[n/ROW_PIX], rm[n/ROW_PIX], n % ROW_PIX),
                   n % ROW_PIX);
        end
      end
      pix_ready = 1'($urandom_range(0, 1));
      row_valid = (acc < 4);
      row_data  = (acc < 4) ? mk_row(rb[acc], rm[acc]) : '0;
      stall = pix_valid && !pix_ready;
      pd = pix_data;
      pc = pix_col;
      if (pix_valid && pix_ready) n++;
      if (row_valid && row_ready) acc++;
      @(negedge clk);
    end
    row_valid = 1'b0;
    pix_ready = 1'b1;
    checks++;
    if (n !== 4 * ROW_PIX) begin
      errors++; $display("FAIL rnd_count got %0d want %0d", n, 4 * ROW_PIX);
    end
  endtask

  task automatic test_flush();
    int budget = 0;
    pix_ready = 1'b1;
    row_valid = 1'b1;
    row_data  = mk_row(4, 3);
    @(negedge clk);
    row_data  = mk_row(8, 5);
    @(negedge clk);
    row_valid = 1'b0;
    while (pix_col !== COL_W'(100) && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (pix_col !== COL_W'(100) || pix_data !== pix(4, 3, 100) || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre got c%0d d%h b%b want c100 d%h b1", pix_col,
               pix_data, busy, pix(4, 3, 100));
    end
    flush     = 1'b1;
    row_valid = 1'b1;
    row_data  = mk_row(6, 7);
    @(negedge clk);
    flush     = 1'b0;
    row_valid = 1'b0;
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || row_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_after got v%b b%b r%b want v0 b0 r1", pix_valid,
               busy, row_ready);
    end
    row_valid = 1'b1;
    @(negedge clk);
    row_valid = 1'b0;
    for (int k = 0; k < ROW_PIX; k++) begin
      checks++;
      if (pix_valid !== 1'b1 || pix_data !== pix(6, 7, k) || pix_col !== COL_W'(k)) begin
        errors++;
        $display("FAIL flush_rowc k=%0d got v%b d%h c%0d want v1 d%h c%0d", k,
                 pix_valid, pix_data, pix_col, pix(6, 7, k), k);
      end
      @(negedge clk);
    end
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++; $display("FAIL flush_end got v%b want 0", pix_valid);
    end
  endtask

  task automatic test_rst_mid();
    pix_ready = 1'b1;
    row_valid = 1'b1;
    row_data  = mk_row(1, 1);
    @(negedge clk);
    row_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst       = 1'b1;
    row_valid = 1'b1;
    row_data  = mk_row(9, 9);
    @(negedge clk);
    rst       = 1'b0;
    row_valid = 1'b0;
    checks++;
    if (row_ready !== 1'b1 || pix_valid !== 1'b0 || pix_data !== '0 ||
        pix_col !== '0 || pix_last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got r%b v%b d%h c%0d l%b b%b want r1 v0 d000 c0 l0 b0",
               row_ready, pix_valid, pix_data, pix_col, pix_last, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_dropped got v%b b%b want v0 b0", pix_valid, busy);
    end
  endtask

  task automatic test_format();
    pixel_t p;
    pix_ready = 1'b1;
    row_valid = 1'b1;
    row_data  = mk_row(12'hF0A, 0);
    @(negedge clk);
    row_valid = 1'b0;
    for (int k = 0; k < ROW_PIX; k++) begin
      p = pix_data;
      checks++;
      if (pix_valid !== 1'b1 || p.r !== 4'hF || p.g !== 4'h0 || p.b !== 4'hA) begin
        errors++;
        $display("FAIL format k=%0d got v%b d%h want v1 dF0A", k, pix_valid,
                 pix_data);
      end
      @(negedge clk);
    end
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++; $display("FAIL format_end got v%b want 0", pix_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_flush();
    test_rst_mid();
    test_format();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
